alu_acc_sequencer: RTL and testbench
====================================

Name: alu_acc_sequencer

Overview:
- Accumulator-based command sequencer sitting directly upstream of the ALU.
- Accepts operation commands over a valid/ready handshake and drives the ALU operand and opcode inputs from an internal accumulator.
- Feeds the ALU result back into the accumulator for a programmable number of iterations (repeated add, multi-bit shift, etc.).
- Returns the final result and flags over a valid/ready response handshake.

Parameters:
- N, 8, datapath width; must match the ALU width.
- CNT_W, 4, width of the repeat-count field; maximum iterations per command = 2^CNT_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command; high only in IDLE
- cmd_load  input  1  1 = load accumulator with cmd_b (no ALU op); 0 = execute cmd_op
- cmd_op  input  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 SHR
- cmd_b  input  N  B operand, or load value when cmd_load=1
- cmd_rep  input  CNT_W  iteration count minus one (0 → 1 iteration)
- alu_a  output  N  to ALU A; always equals the accumulator
- alu_b  output  N  to ALU B; the latched operand
- alu_op  output  3  to ALU opcode; the latched opcode
- alu_y  input  N  ALU result
- alu_cf  input  1  ALU carry flag
- alu_zf  input  1  ALU zero flag
- res_valid  output  1  response available
- res_ready  input  1  consumer accepts the response
- res_y  output  N  result; equals the accumulator
- res_cf  output  1  carry flag of the response
- res_zf  output  1  zero flag of the response

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; accumulator, latched B, latched opcode, and iteration counter all cleared to 0.
  - res_cf=0, res_zf=0, res_valid=0, cmd_ready=1.
  - Takes effect from any state; an in-flight command is aborted and no response is produced.
- FSM states: IDLE, EXEC, RESP. cmd_ready = (state==IDLE). res_valid = (state==RESP). Both are decoded from registered state only.
- IDLE, cmd_valid=1, cmd_load=1 (accepted at edge T0):
  - acc ← cmd_b; cf ← 0; zf ← (cmd_b==0).
  - → RESP; res_valid is high in the cycle after T0.
- IDLE, cmd_valid=1, cmd_load=0 (accepted at edge T0):
  - op ← cmd_op; b ← cmd_b; cnt ← cmd_rep.
  - → EXEC.
- EXEC, each edge:
  - acc ← alu_y; cf ← alu_cf; zf ← alu_zf.
  - If cnt==0: → RESP. Otherwise cnt ← cnt−1.
  - Exactly cmd_rep+1 ALU evaluations occur. res_valid rises after edge T0+cmd_rep+1.
- RESP:
  - Outputs are held stable while res_ready=0; cmd_valid is ignored.
  - On res_ready=1: → IDLE. The next command can be accepted no earlier than the following edge (no same-cycle turnaround).
- ALU inputs are combinational pass-throughs of internal registers. ALU is assumed purely combinational; result is sampled in the same cycle.
- Accumulator persists across commands; only reset or a load changes it outside EXEC.
- Arithmetic wrap-around is modulo 2^N, performed by the ALU. The sequencer does no arithmetic except the counter decrement.
- cmd_rep = 2^CNT_W−1 gives the maximum of 2^CNT_W iterations; the counter never underflows.
- While in EXEC or RESP, cmd_* inputs are don't-care and are not latched.

Optional Feature:
- ALU_ACC_STICKY_CARRY_EN
  - Defined: during EXEC, cf ← cf | alu_cf, with cf cleared on command acceptance. res_cf reports whether any iteration carried, borrowed, or shifted out a 1.
  - Undefined: res_cf is the carry of the final iteration only.
  - res_zf always reflects the final iteration, with or without the macro.

Test Plan:
- Reset, then load 0x0F; then ADD cmd_b=0xF1, rep=0 → res_y=0x00, res_cf=1, res_zf=1; res_valid asserted one cycle after the EXEC edge.
- Load 0x00; ADD cmd_b=0x07, rep=5 → after 6 EXEC cycles res_y=0x2A, res_cf=0, res_zf=0; cmd_ready=0 throughout.
- Load 0x81; SHL rep=2 → res_y=0x08; res_cf=0 without the macro, res_cf=1 with ALU_ACC_STICKY_CARRY_EN.
- Load 0x5A; NOT rep=1 → res_y=0x5A, res_zf=0. Hold res_ready=0 for 5 cycles while pulsing cmd_valid → outputs stable, no command accepted, accumulator unchanged.
- Issue ADD rep=15, assert rst on the 3rd EXEC cycle → next cycle state IDLE, acc=0, res_valid=0, cmd_ready=1, no response emitted.
- Back-to-back: cmd_valid held high with two queued commands → second accepted only on the edge after the first response handshake completes; verify alu_op and alu_b switch only at acceptance.

Source files
------------

// File: rtl/alu_acc_sequencer_if.sv
// alu_acc_sequencer_if
//   Bundles the command handshake, the ALU operand/result bus and the
//   response handshake of the accumulator sequencer.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. The source holds its payload stable while valid is high
//   and ready is low.
//
//   Modports:
//     slave  - the sequencer: takes cmd_*, res_ready and alu_y/cf/zf;
//              drives cmd_ready, alu_a/b/op and res_*.
//     master - the environment around the sequencer (command source, ALU,
//              response sink): the mirror image of slave.
//
//   Parameters: N (datapath width), CNT_W (repeat-count width).
interface alu_acc_sequencer_if #(
  parameter int N     = 8,
  parameter int CNT_W = 4
);
  // command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [2:0]       cmd_op;
  logic [N-1:0]     cmd_b;
  logic [CNT_W-1:0] cmd_rep;
  // ALU side
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [2:0]       alu_op;
  logic [N-1:0]     alu_y;
  logic             alu_cf;
  logic             alu_zf;
  // response channel
  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_y;
  logic             res_cf;
  logic             res_zf;

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_b, cmd_rep,
    input  alu_y, alu_cf, alu_zf,
    input  res_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    output res_valid, res_y, res_cf, res_zf
  );

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_b, cmd_rep,
    output alu_y, alu_cf, alu_zf,
    output res_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    input  res_valid, res_y, res_cf, res_zf
  );
endinterface

// File: rtl/alu_acc_sequencer.sv
// alu_acc_sequencer
//   Accumulator-based command sequencer placed in front of a combinational
//   ALU. A command either loads the accumulator directly (cmd_load=1) or runs
//   cmd_op against the latched B operand for cmd_rep+1 iterations, writing
//   the ALU result back into the accumulator each cycle. The final
//   accumulator value and flags are returned over the response handshake.
//
//   Ports:
//     clk       - rising-edge clock
//     rst       - synchronous, active-high reset (aborts any command)
//     bus       - alu_acc_sequencer_if.slave (command, ALU, response)
//     dbg_state - current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//
//   Build option:
//     ALU_ACC_STICKY_CARRY_EN - when defined, res_cf is the OR of the carry
//     of every iteration of the command; otherwise it is the carry of the
//     final iteration. res_zf always follows the final iteration.
module alu_acc_sequencer #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_acc_sequencer_if.slave      bus,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [N-1:0]     acc;
  logic [N-1:0]     b_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic             cf_q;
  logic             zf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cnt   <= '0;
      cf_q  <= 1'b0;
      zf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_load) begin
              // Direct load bypasses the ALU; flags describe the loaded value.
              acc   <= bus.cmd_b;
              cf_q  <= 1'b0;
              zf_q  <= (bus.cmd_b == '0);
              state <= RESP;
            end else begin
              op_q  <= bus.cmd_op;
              b_q   <= bus.cmd_b;
              cnt   <= bus.cmd_rep;
`ifdef ALU_ACC_STICKY_CARRY_EN
              // Sticky carry accumulates from a clean slate per command.
              cf_q  <= 1'b0;
`endif
              state <= EXEC;
            end
          end
        end

        EXEC: begin
          acc  <= bus.alu_y;
          zf_q <= bus.alu_zf;
`ifdef ALU_ACC_STICKY_CARRY_EN
          cf_q <= cf_q | bus.alu_cf;
`else
          cf_q <= bus.alu_cf;
`endif
          // cnt holds the number of iterations still to run after this one,
          // so the edge seeing cnt==0 is the last evaluation.
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        RESP: begin
          if (bus.res_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // All handshake outputs decode registered state only.
  assign bus.cmd_ready = (state == IDLE);
  assign bus.res_valid = (state == RESP);

  assign bus.alu_a  = acc;
  assign bus.alu_b  = b_q;
  assign bus.alu_op = op_q;

  assign bus.res_y  = acc;
  assign bus.res_cf = cf_q;
  assign bus.res_zf = zf_q;

  assign dbg_state = state;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// tb_alu_acc_sequencer
//   Directed bench for alu_acc_sequencer. A small behavioural ALU closes the
//   loop: ADD (cf = carry out), SUB (cf = borrow), AND/OR/XOR/NOT (cf = 0),
//   SHL/SHR by one bit (cf = bit shifted out); zf = (y == 0).
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_alu_acc_sequencer;

  localparam int N     = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

`ifdef ALU_ACC_STICKY_CARRY_EN
  localparam logic SHL_CF = 1'b1;
`else
  localparam logic SHL_CF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  alu_acc_sequencer_if #(.N(N), .CNT_W(CNT_W)) bus ();

  alu_acc_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- ALU model ----------------
  always_comb begin
    logic [N:0] wide;
    wide = '0;
    bus.alu_cf = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}; bus.alu_cf = wide[N]; end
      OP_SUB: begin wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b}; bus.alu_cf = wide[N]; end
      OP_AND: wide = {1'b0, bus.alu_a & bus.alu_b};
      OP_OR:  wide = {1'b0, bus.alu_a | bus.alu_b};
      OP_XOR: wide = {1'b0, bus.alu_a ^ bus.alu_b};
      OP_NOT: wide = {1'b0, ~bus.alu_a};
      OP_SHL: begin wide = {1'b0, bus.alu_a[N-2:0], 1'b0}; bus.alu_cf = bus.alu_a[N-1]; end
      default: begin wide = {2'b00, bus.alu_a[N-1:1]}; bus.alu_cf = bus.alu_a[0]; end
    endcase
    bus.alu_y  = wide[N-1:0];
    bus.alu_zf = (wide[N-1:0] == '0);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Presents a command and waits (bounded) for it to be accepted.
  task automatic send_cmd(input logic load, input logic [2:0] op,
                          input logic [N-1:0] b, input logic [CNT_W-1:0] rep,
                          input string name);
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = load;
    bus.cmd_op    = op;
    bus.cmd_b     = b;
    bus.cmd_rep   = rep;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check({name, " accept_timeout"}, 32'(n < 50), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Waits for res_valid, checks latency and that cmd_ready stays low.
  task automatic wait_resp(input int exp_lat, input string name);
    int n;
    n = 0;
    while (!bus.res_valid && n < 64) begin
      check({name, " cmd_ready_busy"}, 32'(bus.cmd_ready), 32'd0);
      tick();
      n++;
    end
    check({name, " latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic take_resp();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             load;
    logic [2:0]       op;
    logic [N-1:0]     b;
    logic [CNT_W-1:0] rep;
    logic [N-1:0]     exp_y;
    logic             exp_cf;
    logic             exp_zf;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // Each vector starts from the accumulator left by the previous one.
    vecs[0]  = '{1'b1, OP_ADD, 8'h0F, 4'd0,  8'h0F, 1'b0,   1'b0};
    vecs[1]  = '{1'b0, OP_ADD, 8'hF1, 4'd0,  8'h00, 1'b1,   1'b1};
    vecs[2]  = '{1'b1, OP_ADD, 8'h00, 4'd0,  8'h00, 1'b0,   1'b1};
    vecs[3]  = '{1'b0, OP_ADD, 8'h07, 4'd5,  8'h2A, 1'b0,   1'b0};
    vecs[4]  = '{1'b1, OP_ADD, 8'h81, 4'd0,  8'h81, 1'b0,   1'b0};
    vecs[5]  = '{1'b0, OP_SHL, 8'h00, 4'd2,  8'h08, SHL_CF, 1'b0};
    vecs[6]  = '{1'b1, OP_ADD, 8'h05, 4'd0,  8'h05, 1'b0,   1'b0};
    vecs[7]  = '{1'b0, OP_SUB, 8'h07, 4'd0,  8'hFE, 1'b1,   1'b0};
    vecs[8]  = '{1'b0, OP_AND, 8'h0F, 4'd0,  8'h0E, 1'b0,   1'b0};
    vecs[9]  = '{1'b0, OP_OR,  8'h30, 4'd0,  8'h3E, 1'b0,   1'b0};
    vecs[10] = '{1'b0, OP_XOR, 8'h3E, 4'd0,  8'h00, 1'b0,   1'b1};
    vecs[11] = '{1'b1, OP_ADD, 8'h01, 4'd0,  8'h01, 1'b0,   1'b0};
    vecs[12] = '{1'b0, OP_SHR, 8'h00, 4'd0,  8'h00, 1'b1,   1'b1};
    vecs[13] = '{1'b1, OP_ADD, 8'hF0, 4'd0,  8'hF0, 1'b0,   1'b0};
    // 16 iterations (max count): the last one is 0x00 - 0x10, which borrows.
    vecs[14] = '{1'b0, OP_SUB, 8'h10, 4'd15, 8'hF0, 1'b1,   1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    string nm;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_b     = '0;
    bus.cmd_rep   = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst res_valid", 32'(bus.res_valid), 32'd0);
    check("rst res_y",     32'(bus.res_y),     32'h0);
    check("rst res_cf",    32'(bus.res_cf),    32'd0);
    check("rst res_zf",    32'(bus.res_zf),    32'd0);
    check("rst alu_b",     32'(bus.alu_b),     32'h0);
    check("rst alu_op",    32'(bus.alu_op),    32'h0);
    check("rst state",     32'(dbg_state),     32'd0);

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      nm = $sformatf("vec%0d", i);
      send_cmd(vecs[i].load, vecs[i].op, vecs[i].b, vecs[i].rep, nm);
      wait_resp(vecs[i].load ? 0 : int'(vecs[i].rep) + 1, nm);
      check({nm, " res_y"},  32'(bus.res_y),  32'(vecs[i].exp_y));
      check({nm, " res_cf"}, 32'(bus.res_cf), 32'(vecs[i].exp_cf));
      check({nm, " res_zf"}, 32'(bus.res_zf), 32'(vecs[i].exp_zf));
      take_resp();
      check({nm, " back_idle"}, 32'(bus.cmd_ready), 32'd1);
    end

    // RESP hold: outputs stable, commands ignored while res_ready=0
    send_cmd(1'b1, OP_ADD, 8'h5A, 4'd0, "hold_load");
    wait_resp(0, "hold_load");
    take_resp();
    send_cmd(1'b0, OP_NOT, 8'h00, 4'd1, "hold_not");
    wait_resp(2, "hold_not");
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b1;
    bus.cmd_b     = 8'h33;
    for (int k = 0; k < 5; k++) begin
      check("hold res_valid", 32'(bus.res_valid), 32'd1);
      check("hold res_y",     32'(bus.res_y),     32'h5A);
      check("hold res_zf",    32'(bus.res_zf),    32'd0);
      check("hold cmd_ready", 32'(bus.cmd_ready), 32'd0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    take_resp();
    check("hold after cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("hold after acc",       32'(bus.res_y),     32'h5A);

    // Reset in the 3rd EXEC cycle aborts the command
    send_cmd(1'b0, OP_ADD, 8'h01, 4'd15, "abort");
    check("abort in_exec", 32'(dbg_state), 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort state",     32'(dbg_state),     32'd0);
    check("abort acc",       32'(bus.res_y),     32'h0);
    check("abort res_valid", 32'(bus.res_valid), 32'd0);
    check("abort cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort alu_b",     32'(bus.alu_b),     32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort no_resp", 32'(bus.res_valid), 32'd0);
    end

    // Back-to-back: cmd_valid held, second command waits for the handshake
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = OP_ADD;
    bus.cmd_b     = 8'h03;
    bus.cmd_rep   = 4'd1;
    tick();  // first command accepted here
    bus.cmd_op    = OP_XOR;
    bus.cmd_b     = 8'h55;
    bus.cmd_rep   = 4'd0;
    for (int k = 0; k < 2; k++) begin
      check("b2b exec alu_op", 32'(bus.alu_op), 32'(OP_ADD));
      check("b2b exec alu_b",  32'(bus.alu_b),  32'h03);
      tick();
    end
    check("b2b resp1 valid", 32'(bus.res_valid), 32'd1);
    check("b2b resp1 y",     32'(bus.res_y),     32'h06);
    tick();
    check("b2b resp1 held",  32'(bus.res_valid), 32'd1);
    check("b2b resp1 op",    32'(bus.alu_op),    32'(OP_ADD));
    take_resp();
    check("b2b idle ready",  32'(bus.cmd_ready), 32'd1);
    check("b2b idle op",     32'(bus.alu_op),    32'(OP_ADD));
    check("b2b idle b",      32'(bus.alu_b),     32'h03);
    tick();  // second command accepted here
    bus.cmd_valid = 1'b0;
    check("b2b acc2 op",     32'(bus.alu_op),    32'(OP_XOR));
    check("b2b acc2 b",      32'(bus.alu_b),     32'h55);
    check("b2b acc2 state",  32'(dbg_state),     32'd1);
    wait_resp(1, "b2b cmd2");
    check("b2b resp2 y",     32'(bus.res_y),     32'h53);
    check("b2b resp2 cf",    32'(bus.res_cf),    32'd0);
    check("b2b resp2 zf",    32'(bus.res_zf),    32'd0);
    take_resp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
